// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector.
// Matches a run-time loadable pattern of 1..PAT_W bits against a qualified
// serial stream, in overlapping or non-overlapping mode, and keeps a
// saturating match counter.
module seq_detect_prog #(
   parameter int                PAT_W   = 4,
   parameter int                CNT_W   = 8,
   parameter logic [PAT_W-1:0]  DEF_PAT = 4'b1011,
   parameter int                LEN_W   = $clog2(PAT_W) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic             sin_valid,
   input  logic             sin,
   input  logic             cnt_clr,
   output logic             out,
   output logic [CNT_W-1:0] match_count,
   output logic             armed
);

   localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(PAT_W);

   logic [PAT_W-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             overlap_q, overlap_d;
   logic [PAT_W-1:0] hist_q, hist_d;
   logic [LEN_W-1:0] fill_q, fill_d;
   logic             out_q, out_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;

   logic [PAT_W-1:0] hist_n;
   logic [LEN_W-1:0] fill_n;
   logic             mismatch;
   logic             match;

   // Next-state: config load, bit acceptance, match detection, counter update.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      pattern_d = pattern_q;
      len_d     = len_q;
      overlap_d = overlap_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      cnt_d     = cnt_q;
      match     = 1'b0;
      mismatch  = 1'b0;

      // Candidate history and fill count if the current bit is accepted.
      hist_n = {hist_q[PAT_W-2:0], sin};
      fill_n = (fill_q >= FULL_LEN) ? FULL_LEN : fill_q + LEN_W'(1);

      // Compare only the low len bits; bit len-1 holds the oldest relevant bit.
      for (int i = 0; i < PAT_W; i++) begin
         if ((LEN_W'(i) < len_q) && (hist_n[i] != pattern_q[i])) begin
            mismatch = 1'b1;
         end
      end

      if (cfg_load) begin
         // A load discards any partial sequence and drops a same-cycle bit.
         pattern_d = cfg_pattern;
         len_d     = ((cfg_len == '0) || (cfg_len > FULL_LEN)) ? FULL_LEN : cfg_len;
         overlap_d = cfg_overlap;
         hist_d    = '0;
         fill_d    = '0;
      end else if (sin_valid) begin
         hist_d = hist_n;
         match  = (fill_n >= len_q) && !mismatch;
         // Non-overlap restarts the fill so the next match needs len fresh bits.
         fill_d = (match && !overlap_q) ? '0 : fill_n;
      end

      out_d   = match;
      armed_d = (fill_d >= len_d);

      if (match && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      // Clear wins over a coincident match.
      if (cnt_clr) begin
         cnt_d = '0;
      end
   end

   // State registers with synchronous reset to the default configuration.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         pattern_q <= DEF_PAT;
         len_q     <= FULL_LEN;
         overlap_q <= 1'b1;
         hist_q    <= '0;
         fill_q    <= '0;
         out_q     <= 1'b0;
         cnt_q     <= '0;
         armed_q   <= 1'b0;
      end else begin
         pattern_q <= pattern_d;
         len_q     <= len_d;
         overlap_q <= overlap_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         out_q     <= out_d;
         cnt_q     <= cnt_d;
         armed_q   <= armed_d;
      end
   end

   assign out         = out_q;
   assign match_count = cnt_q;
   assign armed       = armed_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed testbench for seq_detect_prog. A second instance with a 2-bit
// counter shares all inputs and is used to check counter saturation.
module tb_seq_detect_prog;

   localparam int PAT_W = 4;
   localparam int LEN_W = $clog2(PAT_W) + 1;

   logic             clk;
   logic             rst;
   logic             cfg_load;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
   logic             sin_valid;
   logic             sin;
   logic             cnt_clr;
   logic             out;
   logic [7:0]       match_count;
   logic             armed;
   logic             out2;
   logic [1:0]       match_count2;
   logic             armed2;

   int n_checks = 0;
   int n_fail   = 0;

   seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(8)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .sin_valid   (sin_valid),
      .sin         (sin),
      .cnt_clr     (cnt_clr),
      .out         (out),
      .match_count (match_count),
      .armed       (armed)
   );

   seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(2)) u_dut2 (
      .clk         (clk),
      .rst         (rst),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .sin_valid   (sin_valid),
      .sin         (sin),
      .cnt_clr     (cnt_clr),
      .out         (out2),
      .match_count (match_count2),
      .armed       (armed2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic ov);
      cfg_load    = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = ov;
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic clear_cnt();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
   endtask

   // Accept one bit; afterwards out/armed reflect that bit.
   task automatic send(input logic b);
      sin_valid = 1'b1;
      sin       = b;
      tick();
      sin_valid = 1'b0;
   endtask

   // Send a bit stream (MSB of bits first) checking out and armed after each bit.
   task automatic stream(input string tag, input int n, input logic [15:0] bits,
                         input logic [15:0] exp_out, input logic [15:0] exp_armed,
                         input logic chk_armed);
      for (int i = n - 1; i >= 0; i--) begin
         send(bits[i]);
         check($sformatf("%s out bit%0d", tag, n - i), out, exp_out[i]);
         if (chk_armed) check($sformatf("%s armed bit%0d", tag, n - i), armed, exp_armed[i]);
      end
   endtask

   initial begin
      rst = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      sin_valid = 1'b0; sin = 1'b0; cnt_clr = 1'b0;
      #2;

      // Reset state
      do_reset();
      check("reset out", out, 0);
      check("reset count", match_count, 0);
      check("reset armed", armed, 0);

      // Defaults 1011 overlap: stream 1011011
      stream("ovl", 7, 16'b1011011, 16'b0001001, 16'b0001111, 1'b1);
      check("ovl count", match_count, 2);

      // Non-overlap 1011 len 4
      load(4'b1011, 3'd4, 1'b0);
      check("load out", out, 0);
      check("load armed", armed, 0);
      check("load keeps count", match_count, 2);
      clear_cnt();
      check("clr count", match_count, 0);
      stream("novl", 7, 16'b1011011, 16'b0001000, 16'b0000000, 1'b1);
      check("novl count", match_count, 1);

      // len 3 pattern 111 overlap, then non-overlap
      load(4'b0111, 3'd3, 1'b1);
      clear_cnt();
      stream("l3ovl", 5, 16'b11111, 16'b00111, 16'b00111, 1'b1);
      check("l3ovl count", match_count, 3);
      load(4'b0111, 3'd3, 1'b0);
      clear_cnt();
      stream("l3novl", 5, 16'b11111, 16'b00100, 16'b00000, 1'b1);
      check("l3novl count", match_count, 1);

      // Gap with sin_valid low and sin toggling
      do_reset();
      stream("gap pre", 2, 16'b10, 16'b00, 16'b00, 1'b1);
      for (int i = 0; i < 5; i++) begin
         sin = i[0];
         tick();
         check($sformatf("gap out c%0d", i), out, 0);
         check($sformatf("gap armed c%0d", i), armed, 0);
      end
      stream("gap post", 2, 16'b11, 16'b01, 16'b01, 1'b1);
      check("gap count", match_count, 1);

      // Mid-stream reset discards partial sequence
      do_reset();
      stream("rst pre", 3, 16'b101, 16'b000, 16'b000, 1'b0);
      do_reset();
      check("midrst out", out, 0);
      check("midrst count", match_count, 0);
      check("midrst armed", armed, 0);
      stream("rst post", 5, 16'b11011, 16'b00001, 16'b00011, 1'b1);
      check("rst post count", match_count, 1);

      // Length 0 clamps to PAT_W; a bit presented with cfg_load is dropped
      cfg_load = 1'b1; cfg_pattern = 4'b1011; cfg_len = 3'd0; cfg_overlap = 1'b1;
      sin_valid = 1'b1; sin = 1'b1;
      tick();
      cfg_load = 1'b0; sin_valid = 1'b0;
      check("drop armed", armed, 0);
      stream("clamp", 7, 16'b0111011, 16'b0000001, 16'b0001111, 1'b1);

      // Saturation on the 2-bit counter instance, pattern 11 len 2 overlap
      load(4'b0011, 3'd2, 1'b1);
      clear_cnt();
      check("sat clr8", match_count, 0);
      check("sat clr2", match_count2, 0);
      stream("sat", 6, 16'b111111, 16'b011111, 16'b011111, 1'b1);
      check("sat out2", out2, 1);
      check("sat count2", match_count2, 3);
      check("sat count8", match_count, 5);
      cnt_clr = 1'b1;
      send(1'b1);
      cnt_clr = 1'b0;
      check("clr+match out", out, 1);
      check("clr+match count8", match_count, 0);
      check("clr+match count2", match_count2, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
Programmable serial pattern detector; the parametrised successor to the fixed single-pattern sequence detector.
- Takes a qualified serial bit stream and detects a run-time loadable pattern of 1..PAT_W bits.
- Supports overlapping and non-overlapping detection and counts matches in a saturating counter.
- Sits on the serial front end, feeding match pulses and statistics to the control logic.

Parameters:
PAT_W, 4, maximum pattern length in bits (>=2)
CNT_W, 8, width of the match counter
DEF_PAT, 4'b1011, pattern active after reset (PAT_W bits, MSB received first)
LEN_W, $clog2(PAT_W)+1, width of the length field

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
cfg_load  in  1  one-cycle strobe: latch cfg_pattern/cfg_len/cfg_overlap, clear history
cfg_pattern  in  PAT_W  pattern; bit cfg_len-1 is the first bit received, bit 0 the last
cfg_len  in  LEN_W  pattern length; 0 or >PAT_W is treated as PAT_W
cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
sin_valid  in  1  sin qualifier; bit is accepted only when high
sin  in  1  serial data bit
cnt_clr  in  1  clears match_count
out  out  1  one-cycle match pulse
match_count  out  CNT_W  saturating count of matches
armed  out  1  high when at least len bits have been accepted since the last clear

Behaviour:
- Reset is synchronous: rst high at a rising edge sets the following:
  - pattern=DEF_PAT, len=PAT_W, overlap=1
  - hist=0, fill=0
  - out=0, match_count=0, armed=0
- rst overrides every other input.
- State:
  - hist: PAT_W-bit shift register.
  - fill: 0..PAT_W, saturating at PAT_W.
  - Active config registers: pattern, len, overlap.
- Accepted bit (sin_valid=1, cfg_load=0, rst=0):
  - hist_n = {hist[PAT_W-2:0], sin}; fill_n = min(fill+1, PAT_W).
  - match = (fill_n >= len) && (hist_n[len-1:0] == pattern[len-1:0]).
- Latency: out is registered. out=1 in the cycle after the edge that accepted the completing bit, for exactly one cycle per match.
- out=0 in every cycle that follows an edge with no match, including sin_valid=0 cycles.
- Overlap mode: fill continues after a match, so the pattern suffix can start the next match.
- Non-overlap mode: on a match, fill is set to 0 instead of fill_n. hist still shifts.
- sin_valid=0: hist and fill hold; no match.
- cfg_load=1: latches the config.
  - Clamps len: values 0 and >PAT_W become PAT_W.
  - Clears hist and fill; out=0 next cycle.
  - Any sin bit in the same cycle is dropped.
  - match_count is unaffected.
- match_count: increments on each match and saturates at 2^CNT_W-1 without wrapping.
  - cnt_clr sets it to 0.
  - cnt_clr and a match in the same cycle: clear wins (result 0).
- armed = registered (fill >= len). It drops to 0 after cfg_load, after rst, and after a non-overlap match.
- Mid-stream reset or cfg_load: partial sequences are discarded. A full len bits must be received again before the next match.

Test Plan:
- Reset, defaults (1011, overlap): accept 1,0,1,1,0,1,1 -> out pulses after the 4th and 7th bits; match_count=2; armed=1 from the 4th bit onward.
- cfg_load pattern=4'b1011, len=4, overlap=0; same stream -> single pulse after the 4th bit; match_count=1; armed=0 after the match.
- cfg_load pattern=4'b0111, len=3, overlap=1; accept 1,1,1,1,1 -> pulses after bits 3, 4, 5 (count 3). Repeat with overlap=0 -> pulse after bit 3 only (count 1).
- Defaults; send 1,0 then hold sin_valid=0 for 5 cycles with sin toggling, then 1,1 -> no pulse during the gap; single pulse after the final 1; hist is unchanged through the gap.
- Defaults; send 1,0,1, assert rst one cycle, then 1 -> no pulse and match_count=0. Then send 1,0,1,1 -> pulse.
- CNT_W=2, pattern len=2 "11", overlap=1; send six 1s -> five matches, match_count=3 (saturated). cnt_clr together with a match -> match_count=0.
